// File: rtl/lc_event_recorder_if.sv
// Record readout channel of lc_event_recorder: a valid/ready handshake carrying
// the head record (channel mask, start timestamp and length).
interface lc_event_recorder_if #(
  parameter int N_CHANNELS = 24,
  parameter int TS_WIDTH   = 48
);
  logic                  rec_valid;
  logic                  rec_ready;
  logic [N_CHANNELS-1:0] rec_mask;
  logic [TS_WIDTH-1:0]   rec_ts;
  logic [15:0]           rec_len;

  modport master (output rec_valid, output rec_mask, output rec_ts, output rec_len, input rec_ready);
  modport slave  (input rec_valid, input rec_mask, input rec_ts, input rec_len, output rec_ready);
endinterface

// File: rtl/lc_event_recorder.sv
// Turns each contiguous local-coincidence interval into one {mask, ts, len} record,
// queues it in a first-word-fall-through FIFO and keeps event/overflow counters.
module lc_event_recorder #(
  parameter int N_CHANNELS = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 48
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [TS_WIDTH-1:0]             timestamp,
  input  logic [N_CHANNELS-1:0]           local_coinc,
  lc_event_recorder_if.master             rec,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [31:0]                     event_cnt,
  output logic [15:0]                     overflow_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  lc_any_s;
  logic                  start_s;
  logic                  extend_s;
  logic                  commit_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;

  logic [N_CHANNELS-1:0] cur_mask_r;
  logic [TS_WIDTH-1:0]   cur_ts_r;
  logic [15:0]           cur_len_r;

  logic [N_CHANNELS-1:0] mask_mem_r [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   ts_mem_r   [FIFO_DEPTH];
  logic [15:0]           len_mem_r  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [31:0]           event_cnt_r;
  logic [15:0]           overflow_cnt_r;

  assign lc_any_s = |local_coinc;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: stay ACTIVE only while recording is enabled and some channel is set
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   if (enable && lc_any_s) state_nxt_s = ST_ACTIVE; else state_nxt_s = ST_IDLE;
      ST_ACTIVE: if (enable && lc_any_s) state_nxt_s = ST_ACTIVE; else state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: start, extend or commit the interval in progress
  always_comb begin
    start_s  = 1'b0;
    extend_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE:   if (enable && lc_any_s) start_s = 1'b1; else start_s = 1'b0;
      ST_ACTIVE: if (enable && lc_any_s) extend_s = 1'b1; else commit_s = 1'b1;
      default:   commit_s = 1'b0;
    endcase
  end

  // Interval accumulator; length saturates but the interval keeps running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_mask_r <= {N_CHANNELS{1'b0}};
      cur_ts_r   <= {TS_WIDTH{1'b0}};
      cur_len_r  <= 16'd0;
    end else if (start_s) begin
      cur_mask_r <= local_coinc;
      cur_ts_r   <= timestamp;
      cur_len_r  <= 16'd1;
    end else if (extend_s) begin
      cur_mask_r <= cur_mask_r | local_coinc;
      cur_len_r  <= (cur_len_r == 16'hFFFF) ? cur_len_r : cur_len_r + 16'd1;
    end
  end

  // Fullness uses the registered count, so a same-cycle pop never frees room for the push
  assign full_s = (count_r == CW'(FIFO_DEPTH));
  assign push_s = commit_s & ~full_s;
  assign pop_s  = (count_r != {CW{1'b0}}) & rec.rec_ready;

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mask_mem_r[i] <= {N_CHANNELS{1'b0}};
        ts_mem_r[i]   <= {TS_WIDTH{1'b0}};
        len_mem_r[i]  <= 16'd0;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mask_mem_r[wr_ptr_r] <= cur_mask_r;
        ts_mem_r[wr_ptr_r]   <= cur_ts_r;
        len_mem_r[wr_ptr_r]  <= cur_len_r;
        wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Housekeeping counters: events wrap, overflows saturate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_cnt_r    <= 32'd0;
      overflow_cnt_r <= 16'd0;
    end else begin
      if (push_s) begin
        event_cnt_r <= event_cnt_r + 32'd1;
      end
      if (commit_s && full_s && (overflow_cnt_r != 16'hFFFF)) begin
        overflow_cnt_r <= overflow_cnt_r + 16'd1;
      end
    end
  end

  assign rec.rec_valid = (count_r != {CW{1'b0}});
  assign rec.rec_mask  = mask_mem_r[rd_ptr_r];
  assign rec.rec_ts    = ts_mem_r[rd_ptr_r];
  assign rec.rec_len   = len_mem_r[rd_ptr_r];
  assign fifo_count    = count_r;
  assign event_cnt     = event_cnt_r;
  assign overflow_cnt  = overflow_cnt_r;
endmodule

// File: tb/tb_lc_event_recorder.sv
// Directed bench for lc_event_recorder: interval recording, FIFO ordering,
// overflow, enable gating and asynchronous reset.
module tb_lc_event_recorder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [47:0] timestamp;
  logic [23:0] local_coinc;
  logic [3:0]  fifo_count;
  logic [31:0] event_cnt;
  logic [15:0] overflow_cnt;
  int          errors = 0;
  int          checks = 0;

  lc_event_recorder_if #(.N_CHANNELS(24), .TS_WIDTH(48)) rec_if ();

  lc_event_recorder #(.N_CHANNELS(24), .FIFO_DEPTH(8), .TS_WIDTH(48)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .timestamp    (timestamp),
    .local_coinc  (local_coinc),
    .rec          (rec_if),
    .fifo_count   (fifo_count),
    .event_cnt    (event_cnt),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [23:0] m, input logic [47:0] t, input logic [15:0] l);
    check({tag, ".valid"}, {63'd0, rec_if.rec_valid}, 64'd1);
    check({tag, ".mask"},  {40'd0, rec_if.rec_mask}, {40'd0, m});
    check({tag, ".ts"},    {16'd0, rec_if.rec_ts},   {16'd0, t});
    check({tag, ".len"},   {48'd0, rec_if.rec_len},  {48'd0, l});
  endtask

  task automatic check_counts(input string tag, input int cnt, input int ev, input int ov);
    check({tag, ".count"},    {60'd0, fifo_count},   64'(cnt));
    check({tag, ".event"},    {32'd0, event_cnt},    64'(ev));
    check({tag, ".overflow"}, {48'd0, overflow_cnt}, 64'(ov));
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic cyc(input logic en, input logic [47:0] ts, input logic [23:0] lc);
    enable      = en;
    timestamp   = ts;
    local_coinc = lc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n          = 1'b0;
    enable           = 1'b0;
    timestamp        = 48'd0;
    local_coinc      = 24'd0;
    rec_if.rec_ready = 1'b0;
    cyc(1'b0, 48'd0, 24'd0);
    cyc(1'b0, 48'd0, 24'd0);
    check("rst.valid", {63'd0, rec_if.rec_valid}, 64'd0);
    check("rst.mask",  {40'd0, rec_if.rec_mask},  64'd0);
    check("rst.ts",    {16'd0, rec_if.rec_ts},    64'd0);
    check("rst.len",   {48'd0, rec_if.rec_len},   64'd0);
    check_counts("rst", 0, 0, 0);
    reset_n = 1'b1;
    cyc(1'b0, 48'd0, 24'd0);

    // Single event: 4 cycles of 0x3 from ts=1000
    for (int i = 0; i < 4; i++) cyc(1'b1, 48'd1000 + 48'(i), 24'h000003);
    check("single.pre_valid", {63'd0, rec_if.rec_valid}, 64'd0);
    cyc(1'b1, 48'd1004, 24'd0);
    check_head("single", 24'h000003, 48'd1000, 16'd4);
    check_counts("single", 1, 1, 0);
    rec_if.rec_ready = 1'b1;
    cyc(1'b1, 48'd1005, 24'd0);
    rec_if.rec_ready = 1'b0;
    check("single.drained", {63'd0, rec_if.rec_valid}, 64'd0);

    // Mask merge: 0x1 x2 then 0x100 x3 from ts=50
    cyc(1'b1, 48'd50, 24'h000001);
    cyc(1'b1, 48'd51, 24'h000001);
    cyc(1'b1, 48'd52, 24'h000100);
    cyc(1'b1, 48'd53, 24'h000100);
    cyc(1'b1, 48'd54, 24'h000100);
    cyc(1'b1, 48'd55, 24'd0);
    check_head("merge", 24'h000101, 48'd50, 16'd5);
    check_counts("merge", 1, 2, 0);
    rec_if.rec_ready = 1'b1;
    cyc(1'b1, 48'd56, 24'd0);
    rec_if.rec_ready = 1'b0;

    // Back-to-back with a one-cycle gap
    cyc(1'b1, 48'd10, 24'h4);
    cyc(1'b1, 48'd11, 24'h4);
    cyc(1'b1, 48'd12, 24'h0);
    cyc(1'b1, 48'd13, 24'h8);
    cyc(1'b1, 48'd14, 24'h0);
    check_head("b2b.first", 24'h4, 48'd10, 16'd2);
    check_counts("b2b", 2, 4, 0);
    rec_if.rec_ready = 1'b1;
    cyc(1'b1, 48'd15, 24'h0);
    rec_if.rec_ready = 1'b0;
    check_head("b2b.second", 24'h8, 48'd13, 16'd1);
    check("b2b.count1", {60'd0, fifo_count}, 64'd1);
    rec_if.rec_ready = 1'b1;
    cyc(1'b1, 48'd16, 24'h0);
    rec_if.rec_ready = 1'b0;
    check("b2b.empty", {63'd0, rec_if.rec_valid}, 64'd0);

    // Overflow: 10 single-cycle events with the reader stalled
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 48'd300 + 48'(2 * k), 24'(1) << k);
      cyc(1'b1, 48'd301 + 48'(2 * k), 24'd0);
    end
    check_counts("ovf", 8, 12, 2);
    check_head("ovf.head", 24'h000001, 48'd300, 16'd1);
    // Commit while full with a simultaneous pop: record still dropped
    cyc(1'b1, 48'd400, 24'h000800);
    rec_if.rec_ready = 1'b1;
    cyc(1'b1, 48'd401, 24'd0);
    rec_if.rec_ready = 1'b0;
    check_counts("ovf.popfull", 7, 12, 3);
    for (int k = 1; k < 8; k++) begin
      check_head($sformatf("drain%0d", k), 24'(1) << k, 48'd300 + 48'(2 * k), 16'd1);
      rec_if.rec_ready = 1'b1;
      cyc(1'b1, 48'd500, 24'd0);
      rec_if.rec_ready = 1'b0;
    end
    check("drain.valid", {63'd0, rec_if.rec_valid}, 64'd0);
    check("drain.count", {60'd0, fifo_count}, 64'd0);

    // Enable drop mid-interval, then enable rising with lc already high
    cyc(1'b1, 48'd200, 24'hFFFFFF);
    cyc(1'b1, 48'd201, 24'hFFFFFF);
    cyc(1'b1, 48'd202, 24'hFFFFFF);
    cyc(1'b0, 48'd203, 24'hFFFFFF);
    check_head("endrop", 24'hFFFFFF, 48'd200, 16'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 48'd204 + 48'(i), 24'hFFFFFF);
    check_counts("endrop.idle", 1, 13, 3);
    cyc(1'b1, 48'd210, 24'hFFFFFF);
    cyc(1'b1, 48'd211, 24'hFFFFFF);
    cyc(1'b1, 48'd212, 24'd0);
    check_counts("enrise", 2, 14, 3);
    check_head("enrise.stall", 24'hFFFFFF, 48'd200, 16'd3);
    cyc(1'b1, 48'd220, 24'h000010);
    cyc(1'b1, 48'd221, 24'd0);
    check("queued3", {60'd0, fifo_count}, 64'd3);

    // Reset mid-interval with three records queued
    cyc(1'b1, 48'd230, 24'h000020);
    cyc(1'b1, 48'd231, 24'h000020);
    reset_n = 1'b0;
    #1;
    check("amid.valid", {63'd0, rec_if.rec_valid}, 64'd0);
    check("amid.mask",  {40'd0, rec_if.rec_mask},  64'd0);
    check("amid.ts",    {16'd0, rec_if.rec_ts},    64'd0);
    check("amid.len",   {48'd0, rec_if.rec_len},   64'd0);
    check_counts("amid", 0, 0, 0);
    cyc(1'b1, 48'd232, 24'd0);
    reset_n = 1'b1;
    cyc(1'b1, 48'd233, 24'd0);
    cyc(1'b1, 48'd500, 24'h000040);
    cyc(1'b1, 48'd501, 24'd0);
    check_head("fresh", 24'h000040, 48'd500, 16'd1);
    check_counts("fresh", 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc_event_recorder.md
Name: lc_event_recorder

Overview:
Consumer end of the local-coincidence path. It watches the per-channel local_coinc vector produced by the local coincidence block and turns each contiguous coincidence interval into one record: OR'd channel mask, start timestamp and duration. Records are queued in an internal FIFO and read out through a valid/ready interface by the readout/message logic. It also keeps an event counter and an overflow counter for housekeeping.

Parameters:
N_CHANNELS, 24, width of local_coinc and rec_mask
FIFO_DEPTH, 8, number of record entries; power of 2, minimum 2
TS_WIDTH, 48, width of timestamp and rec_ts

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  recording enable; when low, no new records start
timestamp  input  TS_WIDTH  free-running system timestamp, sampled in clk domain
local_coinc  input  N_CHANNELS  per-channel coincidence flags from the local coincidence block
rec_valid  output  1  FIFO head holds a record
rec_ready  input  1  reader accepts the head record
rec_mask  output  N_CHANNELS  head record: OR of local_coinc over the interval
rec_ts  output  TS_WIDTH  head record: timestamp at the first cycle of the interval
rec_len  output  16  head record: interval length in clk cycles, saturating
fifo_count  output  $clog2(FIFO_DEPTH)+1  records currently queued
event_cnt  output  32  records successfully queued, wrapping
overflow_cnt  output  16  records dropped because the FIFO was full, saturating at 0xFFFF

Behaviour:
- Reset (async assert, sync release): state IDLE; FIFO empty; rec_valid=0; rec_mask/rec_ts/rec_len=0; fifo_count=0; event_cnt=0; overflow_cnt=0. Reset mid-interval discards the interval in progress and all queued records.
- lc_any = |local_coinc, evaluated combinationally on the current cycle.
- FSM states: IDLE, ACTIVE.
- IDLE with enable=1 and lc_any=1: capture cur_ts=timestamp, cur_mask=local_coinc, cur_len=1, then go to ACTIVE. IDLE with enable=0: ignore input.
- ACTIVE with lc_any=1 and enable=1:
  - cur_mask |= local_coinc.
  - cur_len += 1, saturating at 0xFFFF. Saturation does not end the interval.
- ACTIVE with lc_any=0 or enable=0 is the commit cycle:
  - Write {cur_mask, cur_ts, cur_len} to the FIFO, then go to IDLE.
  - The commit cycle's local_coinc is not merged in, and it does not add to the length.
- Back-to-back intervals: if lc_any rises in the cycle right after the commit, IDLE starts a new record in that cycle. The minimum gap of one cycle with lc_any=0 yields two records.
- Commit when FIFO not full: push the record and increment event_cnt (32-bit wrap).
- Commit when FIFO full: drop the record and increment overflow_cnt (saturating).
  - Fullness is judged on the registered count at the start of the cycle.
  - A simultaneous pop does not make room for the same-cycle push.
- FIFO is first-word-fall-through with registered storage and pointers:
  - rec_valid = (count != 0).
  - rec_* show the head entry.
  - A pop occurs on rec_valid & rec_ready.
  - rec_ready while empty has no effect.
- Latency: a record committed in cycle N shows on rec_valid/rec_* in cycle N+1 (registered write).
- Simultaneous push and pop with 0<count<FULL: count is unchanged and order is preserved.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is one bit wider so full and empty are unambiguous.
- rec_* must remain stable while rec_valid=1 and rec_ready=0.
- enable falling mid-interval commits a truncated record in the same cycle. enable rising while lc_any is already high starts a record on that cycle, with rec_len counted from then.

Test Plan:
- Single event: enable=1; local_coinc=0x000003 for 4 cycles starting at timestamp 1000 -> one record: mask=0x000003, ts=1000, len=4. rec_valid is high the cycle after lc falls. event_cnt=1.
- Mask merge: 0x000001 for 2 cycles, then 0x000100 for 3 cycles, contiguous, starting at ts=50 -> one record: mask=0x000101, ts=50, len=5.
- Back-to-back: 0x4 for 2 cycles at ts=10, 1 cycle of 0, 0x8 for 1 cycle at ts=13 -> two records in order: (0x4, 10, 2) and (0x8, 13, 1).
- Overflow: rec_ready=0 with FIFO_DEPTH=8; generate 10 single-cycle events -> fifo_count=8, event_cnt=8, overflow_cnt=2. Draining with rec_ready=1 returns the first 8 records in order, and rec_valid then drops.
- Enable drop: 0xFFFFFF held at ts=200; enable falls after 3 ACTIVE cycles -> record (0xFFFFFF, 200, 3). No new record while enable=0, even though lc stays high.
- Reset mid-operation: queue 3 records and assert reset_n=0 mid-interval -> all outputs and counters are 0 immediately (async). After release, a fresh event gives event_cnt=1 and fifo_count=1.
